// File: rtl/lfsr_arbiter_pkg.sv
// Shared definitions for the LFSR random-number server.
//   LFSR_W     : width of the Galois LFSR
//   state_t    : server FSM states
//   lfsr_step  : one Galois step, bit 5 is the MSB and feeds taps 2 and 3
package lfsr_pkg;

   localparam int LFSR_W = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      LOAD  = 2'd2
   } state_t;

   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      logic [LFSR_W-1:0] n;
      n[0] = s[5];
      n[1] = s[0];
      n[2] = s[1] ^ s[5];
      n[3] = s[2] ^ s[5];
      n[4] = s[3];
      n[5] = s[4];
      return n;
   endfunction

endpackage

// File: rtl/lfsr_arbiter_if.sv
// Request/grant and seed-load bus between requesters and the LFSR server.
//   req       : per-requester request, held until its gnt bit is seen
//   gnt       : one-hot grant pulse (one cycle)
//   rnd_out   : random value delivered with the grant
//   rnd_valid : high exactly when gnt is non-zero
//   seed_load : seed load request, honoured only while the server is idle
//   seed_val  : seed to load (zero is replaced by the reset seed)
//   busy      : server is not idle; new req/seed_load must be held
//   lock_err  : one-cycle pulse when a zero seed was replaced
// Handshake: a request is taken only when the server is idle at a rising
// edge; the grant is visible for exactly one cycle after that edge, and the
// requester drops req in the cycle after it sees its gnt bit. Anything
// presented while busy is ignored and has to stay asserted.
interface lfsr_arbiter_if
   import lfsr_pkg::*;
#(
   parameter int N_REQ = 4
) ();

   logic [N_REQ-1:0]  req;
   logic [N_REQ-1:0]  gnt;
   logic [LFSR_W-1:0] rnd_out;
   logic              rnd_valid;
   logic              seed_load;
   logic [LFSR_W-1:0] seed_val;
   logic              busy;
   logic              lock_err;

   modport master (
      output req, seed_load, seed_val,
      input  gnt, rnd_out, rnd_valid, busy, lock_err
   );

   modport slave (
      input  req, seed_load, seed_val,
      output gnt, rnd_out, rnd_valid, busy, lock_err
   );

endinterface

// File: rtl/lfsr_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req       : request vector
//   ptr       : index with the highest priority this round
//   winner    : index of the first set req bit at or above ptr (wrapping)
//   winner_oh : one-hot of winner, all zero when nothing requests
//   any_req   : at least one request bit is set
module rr_arbiter #(
   parameter  int N_REQ = 4,
   localparam int PTR_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [PTR_W-1:0] winner,
   output logic [N_REQ-1:0] winner_oh,
   output logic             any_req
);

   always_comb begin : pick
      logic [PTR_W:0]   sum;
      logic [PTR_W-1:0] idx;
      any_req = 1'b0;
      winner  = '0;
      sum     = '0;
      idx     = '0;
      // Walk ptr, ptr+1, ... with an explicit wrap so N_REQ need not be a
      // power of two.
      for (int i = 0; i < N_REQ; i++) begin
         sum = {1'b0, ptr} + (PTR_W+1)'(i);
         if (sum >= (PTR_W+1)'(N_REQ)) begin
            sum = sum - (PTR_W+1)'(N_REQ);
         end
         idx = sum[PTR_W-1:0];
         if (!any_req && req[idx]) begin
            any_req = 1'b1;
            winner  = idx;
         end
      end
   end

   always_comb begin
      winner_oh = '0;
      for (int j = 0; j < N_REQ; j++) begin
         winner_oh[j] = any_req && (winner == PTR_W'(j));
      end
   end

endmodule

// File: rtl/lfsr_arbiter.sv
// Shared random-number server: one 6-bit Galois LFSR handed out to N_REQ
// requesters in round-robin order, with seed loading and zero-seed recovery.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   bus       : request/grant/seed bus (slave side)
//   dbg_state : current FSM state
//   dbg_ptr   : current round-robin priority pointer
// All outputs are registered; nothing on the bus reaches an output
// combinationally.
module lfsr_arbiter
   import lfsr_pkg::*;
#(
   parameter  int                N_REQ = 4,
   parameter  logic [LFSR_W-1:0] SEED  = 6'b111111,
   localparam int                PTR_W = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             rst,
   lfsr_arbiter_if.slave    bus,
   output state_t           dbg_state,
   output logic [PTR_W-1:0] dbg_ptr
);

   state_t            state_q,     state_d;
   logic [PTR_W-1:0]  ptr_q,       ptr_d;
   logic [LFSR_W-1:0] lfsr_q,      lfsr_d;
   logic [N_REQ-1:0]  gnt_q,       gnt_d;
   logic [LFSR_W-1:0] rnd_q,       rnd_d;
   logic              rnd_valid_q, rnd_valid_d;
   logic              busy_q,      busy_d;
   logic              lock_err_q,  lock_err_d;

   logic [PTR_W-1:0]  winner;
   logic [N_REQ-1:0]  winner_oh;
   logic              any_req;

   rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_rr (
      .req       (bus.req),
      .ptr       (ptr_q),
      .winner    (winner),
      .winner_oh (winner_oh),
      .any_req   (any_req)
   );

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      lfsr_d      = lfsr_q;
      rnd_d       = rnd_q;       // last delivered value stays visible
      gnt_d       = '0;
      rnd_valid_d = 1'b0;
      lock_err_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Seed loading wins over a request in the same cycle.
            if (bus.seed_load) begin
               state_d = LOAD;
               if (bus.seed_val == '0) begin
                  // An all-zero LFSR would never leave zero.
                  lfsr_d     = SEED;
                  lock_err_d = 1'b1;
               end else begin
                  lfsr_d = bus.seed_val;
               end
            end else if (any_req) begin
               state_d     = GRANT;
               gnt_d       = winner_oh;
               rnd_d       = lfsr_q;
               rnd_valid_d = 1'b1;
               lfsr_d      = lfsr_step(lfsr_q);
               if (winner == PTR_W'(N_REQ-1)) begin
                  ptr_d = '0;
               end else begin
                  ptr_d = winner + PTR_W'(1);
               end
            end
         end
         GRANT:   state_d = IDLE;
         LOAD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         lfsr_q      <= SEED;
         gnt_q       <= '0;
         rnd_q       <= '0;
         rnd_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         lock_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         lfsr_q      <= lfsr_d;
         gnt_q       <= gnt_d;
         rnd_q       <= rnd_d;
         rnd_valid_q <= rnd_valid_d;
         busy_q      <= busy_d;
         lock_err_q  <= lock_err_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.rnd_out   = rnd_q;
   assign bus.rnd_valid = rnd_valid_q;
   assign bus.busy      = busy_q;
   assign bus.lock_err  = lock_err_q;
   assign dbg_state     = state_q;
   assign dbg_ptr       = ptr_q;

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Self-checking bench for lfsr_arbiter: directed scenarios plus random
// request/seed traffic, checked against a transaction-level model.
module tb_lfsr_arbiter;
   import lfsr_pkg::*;

   localparam int         N    = 4;
   localparam logic [5:0] SEED = 6'b111111;

   logic       clk;
   logic       rst;
   state_t     dbg_state;
   logic [1:0] dbg_ptr;

   lfsr_arbiter_if #(.N_REQ(N)) bus ();

   lfsr_arbiter #(
      .N_REQ (N),
      .SEED  (SEED)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state),
      .dbg_ptr   (dbg_ptr)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- counters / scoreboard ----------------
   int         n_checks = 0;
   int         n_errors = 0;
   logic [9:0] exp_q[$];   // {gnt, rnd}

   // model state
   logic [5:0] m_lfsr;
   int         m_ptr;
   bit         m_idle;
   logic [3:0] hold_mask;
   int         cyc;

   // last observation
   bit         got_grant;
   logic [3:0] last_gnt;
   logic [5:0] last_rnd;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   // Next LFSR value as a rotate-left with the MSB folded into taps 2 and 3.
   function automatic logic [5:0] ref_next(input logic [5:0] s);
      int v;
      v = ((int'(s) << 1) & 63) | (int'(s) >> 5);
      if (s[5]) v = v ^ 12;
      return 6'(v);
   endfunction

   // Round-robin choice: first requester at or after p, modulo N.
   function automatic int ref_pick(input logic [3:0] r, input int p);
      logic [3:0] sh;
      for (int i = 0; i < N; i++) begin
         sh = r >> ((p + i) % N);
         if (sh[0]) return (p + i) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_lfsr = SEED;
      m_ptr  = 0;
      m_idle = 1'b1;
      exp_q.delete();
   endtask

   // One clock: predict from the inputs driven now, advance, compare.
   task automatic cycle();
      logic [3:0] r;
      logic       sl;
      logic [5:0] sv;
      int         w;
      bit         e_grant, e_busy, e_lock;
      logic [9:0] e;
      r  = bus.req;
      sl = bus.seed_load;
      sv = bus.seed_val;
      e_grant = 0; e_busy = 0; e_lock = 0;
      if (m_idle && sl) begin
         m_lfsr = (sv == 6'd0) ? SEED : sv;
         e_lock = (sv == 6'd0);
         e_busy = 1;
         m_idle = 0;
      end else if (m_idle && r != 4'd0) begin
         w = ref_pick(r, m_ptr);
         exp_q.push_back({4'(1 << w), m_lfsr});
         m_lfsr  = ref_next(m_lfsr);
         m_ptr   = (w + 1) % N;
         e_grant = 1;
         e_busy  = 1;
         m_idle  = 0;
      end else begin
         m_idle = 1;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      check("busy", bus.busy, e_busy);
      check("lock_err", bus.lock_err, e_lock);
      check("rnd_valid", bus.rnd_valid, e_grant);
      got_grant = bus.rnd_valid;
      if (e_grant) begin
         e = exp_q.pop_front();
         check("gnt", bus.gnt, e[9:6]);
         check("rnd_out", bus.rnd_out, e[5:0]);
         check("rnd_nonzero", bus.rnd_out != 6'd0, 1);
         last_gnt = bus.gnt;
         last_rnd = bus.rnd_out;
      end else begin
         check("gnt_quiet", bus.gnt, 0);
      end
      // requesters drop req once they have seen their grant
      bus.req = bus.req & ~(bus.gnt & ~hold_mask);
   endtask

   task automatic wait_grant(input string tag, input int budget);
      int n;
      n = 0;
      got_grant = 0;
      while (!got_grant && n < budget) begin
         cycle();
         n++;
      end
      if (!got_grant) check({tag, "_timeout"}, 0, 1);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      bus.req = '0;
      bus.seed_load = 1'b0;
      bus.seed_val = '0;
      hold_mask = '0;
      repeat (2) @(negedge clk);
      check("rst_gnt", bus.gnt, 0);
      check("rst_rnd_out", bus.rnd_out, 0);
      check("rst_rnd_valid", bus.rnd_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_lock_err", bus.lock_err, 0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      check("rst_ptr", dbg_ptr, 0);
      rst = 1'b1;
      model_reset();
   endtask

   // ---------------- stimulus ----------------
   logic [5:0] vals[200];
   int         at[5];
   logic [3:0] order[5];
   int         obs_period, ref_period;
   logic [5:0] s;

   initial begin
      rst = 1'b0;
      bus.req = '0;
      bus.seed_load = 1'b0;
      bus.seed_val = '0;
      hold_mask = '0;
      cyc = 0;
      model_reset();

      // single requester held: one grant every 2 cycles
      apply_reset();
      hold_mask = 4'b0001;
      bus.req = 4'b0001;
      for (int g = 0; g < 4; g++) begin
         wait_grant("t1", 6);
         vals[g] = last_rnd;
         at[g] = cyc;
      end
      check("t1_v0", vals[0], 6'b111111);
      check("t1_v1", vals[1], 6'b110011);
      check("t1_v2", vals[2], 6'b101011);
      check("t1_v3", vals[3], 6'b011011);
      for (int g = 1; g < 4; g++) check("t1_spacing", at[g] - at[g-1], 2);
      hold_mask = '0;
      bus.req = '0;
      repeat (2) cycle();

      // all four requesting from reset
      apply_reset();
      hold_mask = 4'b0001;
      bus.req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         wait_grant("t2", 6);
         order[g] = last_gnt;
      end
      check("t2_g0", order[0], 4'b0001);
      check("t2_g1", order[1], 4'b0010);
      check("t2_g2", order[2], 4'b0100);
      check("t2_g3", order[3], 4'b1000);
      check("t2_g4", order[4], 4'b0001);
      hold_mask = '0;
      bus.req = '0;
      repeat (2) cycle();

      // seed load beats a simultaneous request
      bus.seed_load = 1'b1;
      bus.seed_val = 6'b000001;
      bus.req = 4'b0100;
      cycle();
      check("t3_load_busy", bus.busy, 1);
      check("t3_no_gnt", bus.gnt, 0);
      bus.seed_load = 1'b0;
      wait_grant("t3", 4);
      check("t3_gnt", last_gnt, 4'b0100);
      check("t3_rnd", last_rnd, 6'b000001);
      repeat (2) cycle();

      // zero seed is replaced and flagged
      bus.seed_load = 1'b1;
      bus.seed_val = 6'b000000;
      cycle();
      check("t4_lock_pulse", bus.lock_err, 1);
      bus.seed_load = 1'b0;
      cycle();
      check("t4_lock_clear", bus.lock_err, 0);
      bus.req = 4'b0010;
      wait_grant("t4", 4);
      check("t4_rnd", last_rnd, 6'b111111);
      repeat (2) cycle();

      // asynchronous reset in the middle of a grant
      bus.req = 4'b1000;
      wait_grant("t5a", 4);
      check("t5_in_grant", bus.rnd_valid, 1);
      #2 rst = 1'b0;
      #1;
      check("t5_gnt_clr", bus.gnt, 0);
      check("t5_valid_clr", bus.rnd_valid, 0);
      check("t5_rnd_clr", bus.rnd_out, 0);
      check("t5_busy_clr", bus.busy, 0);
      #24 rst = 1'b1;
      @(negedge clk);
      model_reset();
      check("t5_ptr", dbg_ptr, 0);
      bus.req = 4'b1001;
      wait_grant("t5b", 4);
      check("t5_gnt", last_gnt, 4'b0001);
      check("t5_rnd", last_rnd, 6'b111111);
      bus.req = '0;
      repeat (2) cycle();

      // random requests and seed loads
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 2) == 0) bus.req = bus.req | 4'($urandom_range(1, 15));
         bus.seed_load = ($urandom_range(0, 11) == 0);
         bus.seed_val = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
         cycle();
         bus.seed_load = 1'b0;
      end
      bus.req = '0;
      repeat (3) cycle();

      // free run of 200 grants from the reset seed
      apply_reset();
      hold_mask = 4'b0001;
      bus.req = 4'b0001;
      for (int g = 0; g < 200; g++) begin
         wait_grant("free", 4);
         vals[g] = last_rnd;
      end
      hold_mask = '0;
      bus.req = '0;
      obs_period = 0;
      for (int i = 1; i < 200; i++) begin
         if (obs_period == 0 && vals[i] == vals[0]) obs_period = i;
      end
      s = SEED;
      ref_period = 0;
      do begin
         s = ref_next(s);
         ref_period++;
      end while (s != SEED && ref_period < 100);
      check("free_start", vals[0], SEED);
      check("free_period", obs_period, ref_period);
      repeat (2) cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
